pixel_filter3x3: RTL

Parametrised streaming pixel processor that generalises the team's single-mode data processor: configurable pixel width and frame geometry, frame-aware row/column tracking, and five operating modes (bypass, invert, 3x3 box blur, 3x3 Sobel magnitude, threshold). It sits between the pixel source and the output DMA/sink on valid/ready streams. It adds start-of-frame and end-of-line sideband outputs and a frame-done pulse. Mode changes and stop requests take effect only at frame boundaries.

---
 rtl/pixel_filter3x3.sv | 324 ++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/pixel_filter3x3.sv
// Streaming 3x3 pixel processor: bypass / invert / box blur / Sobel magnitude / threshold, frame-aware.
// Latency: one cycle from input accept to registered output. Throughput is one pixel per cycle.
// Backpressure: READY_OUT drops while a registered result is waiting on READY_IN. A stalled result is held stable.
//
// Ports:
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   start                     level run request; stop is honoured only at a frame boundary
//   mode, thresh              operating mode (latched per frame) and threshold level (live, per pixel)
//   pixel_in/VALID_IN/READY_OUT    raster-order input stream
//   pixel_out/VALID_OUT/READY_IN   registered result stream
//   sof_out, eol_out          first-pixel-of-frame / last-pixel-of-row markers, qualified by VALID_OUT
//   frame_done                one-cycle pulse after the last input pixel of a frame is accepted
//   busy                      high while the run state machine is not idle
module pixel_filter3x3 #(
    parameter int PIX_W      = 8,
    parameter int IMG_WIDTH  = 32,
    parameter int IMG_HEIGHT = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [PIX_W-1:0] thresh,
    input  logic [PIX_W-1:0] pixel_in,
    input  logic             VALID_IN,
    output logic             READY_OUT,
    output logic [PIX_W-1:0] pixel_out,
    output logic             VALID_OUT,
    input  logic             READY_IN,
    output logic             sof_out,
    output logic             eol_out,
    output logic             frame_done,
    output logic             busy
);

    localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    // Four guard bits hold the 9-pixel box sum and the signed Sobel gradients.
    localparam int SW = PIX_W + 4;

    localparam logic [CW-1:0]    C_LAST  = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0]    R_LAST  = RW'(IMG_HEIGHT - 1);
    localparam logic [PIX_W-1:0] PIX_MAX = '1;
    localparam logic [SW-1:0]    SAT_LIM = SW'(PIX_MAX);

    localparam logic [2:0] M_BYPASS = 3'b000;
    localparam logic [2:0] M_INVERT = 3'b001;
    localparam logic [2:0] M_BOX    = 3'b010;
    localparam logic [2:0] M_SOBEL  = 3'b011;
    localparam logic [2:0] M_THRESH = 3'b100;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [2:0]        r_mode_q;
    logic [CW-1:0]     r_col;
    logic [RW-1:0]     r_row;

    logic [PIX_W-1:0]  r_pixel_out;
    logic              r_vld_out;
    logic              r_sof;
    logic              r_eol;
    logic              r_frame_done;

    // Two previous rows, indexed by column. Contents are don't-care until
    // written by the current frame, so they carry no reset.
    logic [PIX_W-1:0]  r_lb0 [IMG_WIDTH];
    logic [PIX_W-1:0]  r_lb1 [IMG_WIDTH];

    // Two most recent window columns, [row][col]: row 0 oldest, col 1 newest.
    // The third (newest) column is formed combinationally from the line
    // buffers and pixel_in, so the result is ready in the accept cycle.
    logic [PIX_W-1:0]  r_win [3][2];

    logic              w_accept;
    logic              w_first;
    logic              w_last;
    logic              w_frame_wrap;
    logic              w_boundary;
    logic              w_mode_ld;
    logic              w_win_ok;

    logic [PIX_W-1:0]  w_col_new [3];
    logic [PIX_W-1:0]  w_p [3][3];

    logic [SW-1:0]         w_box_sum;
    logic [SW-1:0]         w_box_shr;
    logic [PIX_W-1:0]      w_box_res;
    logic signed [SW-1:0]  w_gx;
    logic signed [SW-1:0]  w_gy;
    logic [SW-1:0]         w_abs_x;
    logic [SW-1:0]         w_abs_y;
    logic [SW-1:0]         w_mag;
    logic [PIX_W-1:0]      w_sob_res;

    logic [PIX_W-1:0]  w_res;
    logic              w_produce;
    logic              w_sof;
    logic              w_eol;

    function automatic logic signed [SW-1:0] f_sx(input logic [PIX_W-1:0] v);
        return $signed(SW'(v));
    endfunction

    // ------------------------------------------------------------------
    // Handshake and frame position
    // ------------------------------------------------------------------
    assign READY_OUT    = (r_state == S_RUN) && (!r_vld_out || READY_IN);
    assign w_accept     = VALID_IN && READY_OUT;
    assign w_first      = (r_row == '0) && (r_col == '0);
    assign w_last       = (r_row == R_LAST) && (r_col == C_LAST);
    assign w_frame_wrap = w_accept && w_last;
    // A frame that has just had its first pixel accepted is already in
    // progress, so that cycle does not count as a boundary.
    assign w_boundary   = (w_first && !w_accept) || w_frame_wrap;
    assign w_win_ok     = (r_row >= RW'(2)) && (r_col >= CW'(2));

    // ------------------------------------------------------------------
    // Run FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_mode_ld   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                    w_mode_ld   = 1'b1;
                end
            end
            S_RUN: begin
                if (w_boundary) begin
                    w_mode_ld = 1'b1;
                    if (!start) begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode_q <= M_BYPASS;
        end else if (w_mode_ld) begin
            r_mode_q <= mode;
        end
    end

    // ------------------------------------------------------------------
    // Raster counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (r_state == S_IDLE) begin
            if (start) begin
                r_col <= '0;
                r_row <= '0;
            end
        end else if (w_accept) begin
            if (r_col == C_LAST) begin
                r_col <= '0;
                r_row <= (r_row == R_LAST) ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Line buffers and window
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lb1[r_col] <= r_lb0[r_col];
            r_lb0[r_col] <= pixel_in;
        end
    end

    always_comb begin
        w_col_new[0] = r_lb1[r_col];
        w_col_new[1] = r_lb0[r_col];
        w_col_new[2] = pixel_in;
        for (int r = 0; r < 3; r++) begin
            w_p[r][0] = r_win[r][0];
            w_p[r][1] = r_win[r][1];
            w_p[r][2] = w_col_new[r];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 3; r++) begin
                r_win[r][0] <= '0;
                r_win[r][1] <= '0;
            end
        end else if (w_accept) begin
            for (int r = 0; r < 3; r++) begin
                r_win[r][0] <= r_win[r][1];
                r_win[r][1] <= w_col_new[r];
            end
        end
    end

    // ------------------------------------------------------------------
    // Box blur: sum of nine, divided by eight (not nine), saturated
    // ------------------------------------------------------------------
    always_comb begin
        w_box_sum = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                w_box_sum = w_box_sum + SW'(w_p[r][c]);
            end
        end
    end

    assign w_box_shr = w_box_sum >> 3;
    assign w_box_res = (w_box_shr > SAT_LIM) ? PIX_MAX : w_box_shr[PIX_W-1:0];

    // ------------------------------------------------------------------
    // Sobel magnitude |Gx| + |Gy|, saturated
    // ------------------------------------------------------------------
    always_comb begin
        w_gx = (f_sx(w_p[0][2]) + (f_sx(w_p[1][2]) <<< 1) + f_sx(w_p[2][2]))
             - (f_sx(w_p[0][0]) + (f_sx(w_p[1][0]) <<< 1) + f_sx(w_p[2][0]));
        w_gy = (f_sx(w_p[2][0]) + (f_sx(w_p[2][1]) <<< 1) + f_sx(w_p[2][2]))
             - (f_sx(w_p[0][0]) + (f_sx(w_p[0][1]) <<< 1) + f_sx(w_p[0][2]));
    end

    assign w_abs_x   = w_gx[SW-1] ? $unsigned(-w_gx) : $unsigned(w_gx);
    assign w_abs_y   = w_gy[SW-1] ? $unsigned(-w_gy) : $unsigned(w_gy);
    assign w_mag     = w_abs_x + w_abs_y;
    assign w_sob_res = (w_mag > SAT_LIM) ? PIX_MAX : w_mag[PIX_W-1:0];

    // ------------------------------------------------------------------
    // Result select
    // ------------------------------------------------------------------
    always_comb begin
        w_res     = '0;
        w_produce = 1'b0;
        w_sof     = 1'b0;
        w_eol     = (r_col == C_LAST);
        case (r_mode_q)
            M_BYPASS: begin
                w_res     = pixel_in;
                w_produce = 1'b1;
                w_sof     = w_first;
            end
            M_INVERT: begin
                w_res     = ~pixel_in;
                w_produce = 1'b1;
                w_sof     = w_first;
            end
            M_THRESH: begin
                w_res     = (pixel_in >= thresh) ? PIX_MAX : '0;
                w_produce = 1'b1;
                w_sof     = w_first;
            end
            // Window modes emit only fully-populated windows; the window
            // ending at (2,2) is the first of the frame.
            M_BOX: begin
                w_res     = w_box_res;
                w_produce = w_win_ok;
                w_sof     = (r_row == RW'(2)) && (r_col == CW'(2));
            end
            M_SOBEL: begin
                w_res     = w_sob_res;
                w_produce = w_win_ok;
                w_sof     = (r_row == RW'(2)) && (r_col == CW'(2));
            end
            default: begin
                w_produce = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pixel_out  <= '0;
            r_vld_out    <= 1'b0;
            r_sof        <= 1'b0;
            r_eol        <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_frame_wrap;
            if (w_accept && w_produce) begin
                r_pixel_out <= w_res;
                r_vld_out   <= 1'b1;
                r_sof       <= w_sof;
                r_eol       <= w_eol;
            end else if (READY_IN) begin
                // Consumed (or already empty); data fields keep their
                // last value since they are only meaningful with VALID_OUT.
                r_vld_out <= 1'b0;
            end
        end
    end

    assign pixel_out  = r_pixel_out;
    assign VALID_OUT  = r_vld_out;
    assign sof_out    = r_sof;
    assign eol_out    = r_eol;
    assign frame_done = r_frame_done;
    assign busy       = (r_state != S_IDLE);

endmodule
